// File: rtl/ara_issue_broadcaster_if.sv
// Issue bus between the sequencer, the PEs and ara_issue_broadcaster.
// slave: broadcaster side; master: sequencer/PE side driving requests.
interface ara_issue_broadcaster_if #(
   parameter int unsigned NrLanes = 4,
   parameter int unsigned NrPEs   = NrLanes + 4,
   parameter int unsigned NrVInsn = 8,
   parameter int unsigned IdW     = $clog2(NrVInsn)
);
   logic                            issue_valid_i;
   logic                            issue_ready_o;
   logic [NrPEs-1:0]                issue_pe_mask_i;
   logic [IdW-1:0]                  issue_id_o;
   logic [NrPEs-1:0]                pe_valid_o;
   logic [NrPEs-1:0]                pe_ready_i;
   logic [IdW-1:0]                  pe_id_o;
   logic [NrPEs-1:0][NrVInsn-1:0]   pe_done_i;
   logic [NrVInsn-1:0]              vinsn_running_o;
   logic                            idle_o;

   modport slave (
      input  issue_valid_i,
      input  issue_pe_mask_i,
      input  pe_ready_i,
      input  pe_done_i,
      output issue_ready_o,
      output issue_id_o,
      output pe_valid_o,
      output pe_id_o,
      output vinsn_running_o,
      output idle_o
   );

   modport master (
      output issue_valid_i,
      output issue_pe_mask_i,
      output pe_ready_i,
      output pe_done_i,
      input  issue_ready_o,
      input  issue_id_o,
      input  pe_valid_o,
      input  pe_id_o,
      input  vinsn_running_o,
      input  idle_o
   );
endinterface

// File: rtl/ara_issue_broadcaster.sv
// Accepts one vector instruction at a time, allocates the lowest free ID,
// broadcasts it to the masked PEs with per-PE valid/ready and tracks
// per-PE running bits cleared by completion pulses.
// Ports: clk_i, rst_ni (async, active-low), bus (issue/PE/done/status).
module ara_issue_broadcaster #(
   parameter int unsigned NrLanes = 4,
   parameter int unsigned NrPEs   = NrLanes + 4,
   parameter int unsigned NrVInsn = 8
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   ara_issue_broadcaster_if.slave bus
);
   localparam int unsigned IdW = $clog2(NrVInsn);

   typedef enum logic {
      IDLE,
      BCAST
   } state_e;

   state_e                        state_q, state_d;
   logic [NrPEs-1:0]              pending_q, pending_d;
   logic [IdW-1:0]                id_q, id_d;
   logic [NrPEs-1:0][NrVInsn-1:0] running_q, running_d;

   logic [NrVInsn-1:0] vinsn_running;
   logic [IdW-1:0]     free_id;
   logic               full;
   logic               issue_ready;
   logic               accept;
   logic               alloc;
   logic [NrPEs-1:0]   pending_left;

   // Global view of which IDs are held by any PE.
   always_comb begin
      vinsn_running = '0;
      for (int p = 0; p < int'(NrPEs); p++) begin
         vinsn_running = vinsn_running | running_q[p];
      end
   end

   // Scanning downwards leaves the lowest free index in free_id.
   always_comb begin
      free_id = '0;
      for (int i = int'(NrVInsn) - 1; i >= 0; i--) begin
         if (!vinsn_running[i]) begin
            free_id = IdW'(i);
         end
      end
   end

   assign full         = &vinsn_running;
   assign issue_ready  = (state_q == IDLE) && !full;
   assign accept       = bus.issue_valid_i && issue_ready;
   assign alloc        = accept && (|bus.issue_pe_mask_i);
   assign pending_left = pending_q & ~bus.pe_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         pending_q <= '0;
         id_q      <= '0;
         running_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         id_q      <= id_d;
         running_q <= running_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (alloc) begin
               state_d = BCAST;
            end
         end
         BCAST: begin
            if (pending_left == '0) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Done clears first, so a same-cycle set on the same bit wins.
   always_comb begin
      pending_d = pending_q;
      id_d      = id_q;
      running_d = running_q & ~bus.pe_done_i;
      if (state_q == BCAST) begin
         pending_d = pending_left;
      end
      if (alloc) begin
         pending_d = bus.issue_pe_mask_i;
         id_d      = free_id;
         for (int p = 0; p < int'(NrPEs); p++) begin
            if (bus.issue_pe_mask_i[p]) begin
               running_d[p][free_id] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.issue_ready_o   = issue_ready;
      bus.issue_id_o      = free_id;
      bus.pe_valid_o      = (state_q == BCAST) ? pending_q : '0;
      bus.pe_id_o         = id_q;
      bus.vinsn_running_o = vinsn_running;
      bus.idle_o          = !(|vinsn_running) && (state_q == IDLE);
   end
endmodule

// File: tb/tb_ara_issue_broadcaster.sv
// Directed bench for ara_issue_broadcaster with an ownership-based model.
// Checks every output on each falling edge plus literal spot values.
module tb_ara_issue_broadcaster;
   localparam int NrLanes = 4;
   localparam int NrPEs   = 8;
   localparam int NrVInsn = 8;
   localparam int IdW     = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ara_issue_broadcaster_if #(
      .NrLanes(NrLanes), .NrPEs(NrPEs), .NrVInsn(NrVInsn)
   ) bus ();

   ara_issue_broadcaster #(
      .NrLanes(NrLanes), .NrPEs(NrPEs), .NrVInsn(NrVInsn)
   ) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model: for each ID, the set of PEs still owning it.
   int unsigned owners[NrVInsn] = '{default: 0};
   bit          bcast = 1'b0;
   int unsigned outst = 0;
   int unsigned bid   = 0;
   int unsigned m_fid;

   function automatic int unsigned first_free();
      for (int i = 0; i < NrVInsn; i++)
         if (owners[i] == 0) return i;
      return NrVInsn;
   endfunction

   function automatic logic [NrVInsn-1:0] m_running();
      logic [NrVInsn-1:0] r = '0;
      for (int i = 0; i < NrVInsn; i++) r[i] = (owners[i] != 0);
      return r;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h",
                  name, $time, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NrVInsn; i++) owners[i] = 0;
         bcast = 1'b0;
         outst = 0;
         bid   = 0;
      end else begin
         m_fid = first_free();
         for (int p = 0; p < NrPEs; p++)
            for (int i = 0; i < NrVInsn; i++)
               if (bus.pe_done_i[p][i]) owners[i] &= ~(32'd1 << p);
         if (bcast) begin
            outst &= ~32'(bus.pe_ready_i);
            if (outst == 0) bcast = 1'b0;
         end else if (bus.issue_valid_i && m_fid < NrVInsn
                      && bus.issue_pe_mask_i != '0) begin
            owners[m_fid] |= 32'(bus.issue_pe_mask_i);
            bcast = 1'b1;
            outst = 32'(bus.issue_pe_mask_i);
            bid   = m_fid;
         end
      end
   end

   always @(negedge clk) begin
      logic exp_rdy;
      exp_rdy = !bcast && (first_free() < NrVInsn);
      cmp("issue_ready", 32'(bus.issue_ready_o), 32'(exp_rdy));
      if (exp_rdy)
         cmp("issue_id", 32'(bus.issue_id_o), first_free());
      cmp("pe_valid", 32'(bus.pe_valid_o), bcast ? outst : 0);
      cmp("pe_id", 32'(bus.pe_id_o), bid);
      cmp("vinsn_running", 32'(bus.vinsn_running_o), 32'(m_running()));
      cmp("idle", 32'(bus.idle_o),
          32'((m_running() == '0) && !bcast));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [NrPEs-1:0] m);
      bus.issue_valid_i   = 1'b1;
      bus.issue_pe_mask_i = m;
      tick();
      bus.issue_valid_i   = 1'b0;
      bus.issue_pe_mask_i = '0;
   endtask

   task automatic pulse_done(input logic [NrPEs-1:0] pes, input int id);
      for (int p = 0; p < NrPEs; p++)
         if (pes[p]) bus.pe_done_i[p][id] = 1'b1;
      tick();
      bus.pe_done_i = '0;
   endtask

   initial begin
      bus.issue_valid_i   = 1'b0;
      bus.issue_pe_mask_i = '0;
      bus.pe_ready_i      = '1;
      bus.pe_done_i       = '0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;

      // Reset values
      @(negedge clk);
      cmp("rst_ready", 32'(bus.issue_ready_o), 1);
      cmp("rst_id", 32'(bus.issue_id_o), 0);
      cmp("rst_idle", 32'(bus.idle_o), 1);
      cmp("rst_running", 32'(bus.vinsn_running_o), 0);

      // Single issue to lanes, all ready
      issue(8'h0F);
      @(negedge clk);
      cmp("t1_valid", 32'(bus.pe_valid_o), 32'h0F);
      cmp("t1_peid", 32'(bus.pe_id_o), 0);
      cmp("t1_running", 32'(bus.vinsn_running_o), 32'h01);
      cmp("t1_busy", 32'(bus.issue_ready_o), 0);
      tick();
      @(negedge clk);
      cmp("t1_valid_off", 32'(bus.pe_valid_o), 0);
      cmp("t1_ready", 32'(bus.issue_ready_o), 1);
      cmp("t1_next_id", 32'(bus.issue_id_o), 1);
      pulse_done(8'h0F, 0);
      @(negedge clk);
      cmp("t1_idle", 32'(bus.idle_o), 1);

      // Lane 2 stalls for 5 cycles
      bus.pe_ready_i = 8'hFB;
      issue(8'h0F);
      @(negedge clk);
      cmp("t2_valid0", 32'(bus.pe_valid_o), 32'h0F);
      for (int k = 0; k < 5; k++) begin
         tick();
         @(negedge clk);
         cmp("t2_stall_valid", 32'(bus.pe_valid_o), 32'h04);
         cmp("t2_stall_ready", 32'(bus.issue_ready_o), 0);
      end
      bus.pe_ready_i = '1;
      tick();
      @(negedge clk);
      cmp("t2_valid_off", 32'(bus.pe_valid_o), 0);
      cmp("t2_ready", 32'(bus.issue_ready_o), 1);
      pulse_done(8'h0F, 0);

      // Fill all IDs with load-unit instructions
      for (int k = 0; k < NrVInsn; k++) begin
         issue(8'h10);
         tick();
      end
      @(negedge clk);
      cmp("t3_full_ready", 32'(bus.issue_ready_o), 0);
      cmp("t3_full_running", 32'(bus.vinsn_running_o), 32'hFF);
      pulse_done(8'h10, 3);
      @(negedge clk);
      cmp("t3_free_id", 32'(bus.issue_id_o), 3);
      cmp("t3_free_ready", 32'(bus.issue_ready_o), 1);
      for (int i = 0; i < NrVInsn; i++) pulse_done(8'h10, i);

      // Lanes plus mask unit on ID 0
      issue(8'h8F);
      tick();
      pulse_done(8'h0F, 0);
      @(negedge clk);
      cmp("t4_partial_run", 32'(bus.vinsn_running_o), 32'h01);
      cmp("t4_partial_idle", 32'(bus.idle_o), 0);
      pulse_done(8'h80, 0);
      @(negedge clk);
      cmp("t4_run_clear", 32'(bus.vinsn_running_o), 0);
      cmp("t4_idle", 32'(bus.idle_o), 1);

      // Zero mask and spurious done
      issue(8'h01);
      tick();
      issue(8'h00);
      @(negedge clk);
      cmp("t5_valid", 32'(bus.pe_valid_o), 0);
      cmp("t5_running", 32'(bus.vinsn_running_o), 32'h01);
      cmp("t5_id", 32'(bus.issue_id_o), 1);
      cmp("t5_ready", 32'(bus.issue_ready_o), 1);
      pulse_done(8'h04, 5);
      @(negedge clk);
      cmp("t5_spurious", 32'(bus.vinsn_running_o), 32'h01);
      pulse_done(8'h01, 0);

      // Reset during broadcast
      bus.pe_ready_i = 8'hCF;
      issue(8'h30);
      @(negedge clk);
      cmp("t6_valid", 32'(bus.pe_valid_o), 32'h30);
      #1 rst_n = 1'b0;
      #1;
      cmp("t6_rst_valid", 32'(bus.pe_valid_o), 0);
      cmp("t6_rst_running", 32'(bus.vinsn_running_o), 0);
      cmp("t6_rst_idle", 32'(bus.idle_o), 1);
      cmp("t6_rst_ready", 32'(bus.issue_ready_o), 1);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      bus.pe_ready_i = '1;
      @(negedge clk);
      cmp("t6_post_ready", 32'(bus.issue_ready_o), 1);
      cmp("t6_post_idle", 32'(bus.idle_o), 1);
      cmp("t6_post_id", 32'(bus.issue_id_o), 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end
endmodule
